status_arb_rr: RTL and testbench

//  N-channel status-report arbiter between the DDR channel FSMs and the single status port.

---
 rtl/status_arb_rr.sv | 138 +++++++++++++
 tb/tb_status_arb_rr.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/status_arb_rr.sv
// status_arb_rr: N-channel round-robin status-report arbiter.
// Latches per-channel request pulses, grants one channel when the consumer is
// idle, forwards that channel's status word with a one-cycle ack, then waits in
// HOLD until the consumer leaves idle before arbitrating again.
// Optional feature: define STATUS_ARB_OVF_CNT_EN to add ovf_cnt_o, a saturating
// count of duplicate requests merged into an already-pending request.
module status_arb_rr #(
  parameter  int NUM_CH = 6,
  parameter  int DW     = 31,
  localparam int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 status_idle_i,
  output logic                 status_ack_o,
  output logic [DW-1:0]        status_data_o,
  output logic [CW-1:0]        status_src_o,
  input  logic [NUM_CH-1:0]    ch_ack_i,
  input  logic [NUM_CH*DW-1:0] ch_data_i,
  output logic [NUM_CH-1:0]    ch_grant_o
`ifdef STATUS_ARB_OVF_CNT_EN
  ,
  output logic [15:0]          ovf_cnt_o
`endif
);

  typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

  state_t              r_state;
  logic [NUM_CH-1:0]   r_pend;
  logic [NUM_CH-1:0]   r_grant;
  logic [CW-1:0]       r_rr_ptr;
  logic [CW-1:0]       r_idx;
  logic                r_ack;
  logic [DW-1:0]       r_data;
  logic [CW-1:0]       r_src;

  logic                w_any;
  logic [CW-1:0]       w_sel;
  logic [CW-1:0]       w_next_ptr;
  logic [DW-1:0]       w_gdata;

  assign w_any   = |r_pend;
  assign w_gdata = ch_data_i[int'(r_idx)*DW +: DW];

  // First pending channel at or after the round-robin pointer, wrapping at NUM_CH.
  always_comb begin
    int   j;
    logic found;
    w_sel = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      j = int'(r_rr_ptr) + i;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (!found && r_pend[j]) begin
        found = 1'b1;
        w_sel = CW'(j);
      end
    end
  end

  // Pointer wraps explicitly so non-power-of-two channel counts stay in range.
  assign w_next_ptr = (w_sel == CW'(NUM_CH - 1)) ? '0 : CW'(w_sel + 1'b1);

  // Pending flags: a new request wins over the clear from a same-cycle grant.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_pend <= '0;
    else         r_pend <= (r_pend & ~r_grant) | ch_ack_i;
  end

  // Arbitration FSM; every output is a register written here.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_idx    <= '0;
      r_ack    <= 1'b0;
      r_data   <= '0;
      r_src    <= '0;
    end else begin
      r_ack   <= 1'b0;
      r_grant <= '0;
      case (r_state)
        IDLE: begin
          if (status_idle_i && w_any) begin
            r_grant[w_sel] <= 1'b1;
            r_idx          <= w_sel;
            r_rr_ptr       <= w_next_ptr;
            r_state        <= GRANT;
          end
        end
        GRANT: begin
          r_data  <= w_gdata;
          r_src   <= r_idx;
          r_ack   <= 1'b1;
          r_state <= HOLD;
        end
        HOLD: begin
          // Wait for the consumer to go busy so one report is never granted twice.
          if (!status_idle_i) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ch_grant_o    = r_grant;
  assign status_ack_o  = r_ack;
  assign status_data_o = r_data;
  assign status_src_o  = r_src;

`ifdef STATUS_ARB_OVF_CNT_EN
  logic [15:0]       r_ovf;
  logic [NUM_CH-1:0] w_drop;
  logic [6:0]        w_ndrop;
  logic [16:0]       w_sum;

  // Duplicates: request on an already-pending channel not being granted now.
  always_comb begin
    w_drop  = ch_ack_i & r_pend & ~r_grant;
    w_ndrop = '0;
    for (int i = 0; i < NUM_CH; i++) w_ndrop = w_ndrop + 7'(w_drop[i]);
    w_sum   = {1'b0, r_ovf} + 17'(w_ndrop);
  end

  // Saturating drop counter, cleared only by reset.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)     r_ovf <= '0;
    else if (w_sum[16]) r_ovf <= 16'hFFFF;
    else             r_ovf <= w_sum[15:0];
  end

  assign ovf_cnt_o = r_ovf;
`endif

endmodule

// File: tb/tb_status_arb_rr.sv
// Directed self-checking bench for status_arb_rr (NUM_CH=6, DW=31).
module tb_status_arb_rr;
  localparam int NUM_CH = 6;
  localparam int DW     = 31;
  localparam int CW     = 3;

  logic                 sys_clk = 1'b0;
  logic                 sys_rst = 1'b0;
  logic                 status_idle_i = 1'b0;
  logic                 status_ack_o;
  logic [DW-1:0]        status_data_o;
  logic [CW-1:0]        status_src_o;
  logic [NUM_CH-1:0]    ch_ack_i = '0;
  logic [NUM_CH*DW-1:0] ch_data_i;
  logic [NUM_CH-1:0]    ch_grant_o;
`ifdef STATUS_ARB_OVF_CNT_EN
  logic [15:0]          ovf_cnt_o;
`endif

  int total = 0;
  int bad   = 0;

  status_arb_rr #(.NUM_CH(NUM_CH), .DW(DW)) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .status_idle_i (status_idle_i),
    .status_ack_o  (status_ack_o),
    .status_data_o (status_data_o),
    .status_src_o  (status_src_o),
    .ch_ack_i      (ch_ack_i),
    .ch_data_i     (ch_data_i),
    .ch_grant_o    (ch_grant_o)
`ifdef STATUS_ARB_OVF_CNT_EN
    ,
    .ovf_cnt_o     (ovf_cnt_o)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [DW-1:0] word(int k);
    return DW'(32'h1234_5000 + k * 32'h0001_0111);
  endfunction

  initial begin
    for (int k = 0; k < NUM_CH; k++) ch_data_i[k*DW +: DW] = word(k);
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst  = 1'b1;
    ch_ack_i = '0;
    tick();
    tick();
    sys_rst  = 1'b0;
  endtask

  task automatic pulse(input logic [NUM_CH-1:0] m);
    ch_ack_i = m;
    tick();
    ch_ack_i = '0;
  endtask

  // Consumer takes the report: idle low for one cycle.
  task automatic release_consumer();
    status_idle_i = 1'b0;
    tick();
    status_idle_i = 1'b1;
  endtask

  task automatic wait_grant(output logic [NUM_CH-1:0] g);
    g = '0;
    for (int i = 0; i < 12; i++) begin
      if (ch_grant_o != '0) break;
      tick();
    end
    g = ch_grant_o;
  endtask

  task automatic test_reset();
    logic [NUM_CH-1:0] g;
    do_reset();
    total++; if (ch_grant_o !== 6'b0 || status_ack_o !== 1'b0 || status_data_o !== '0 || status_src_o !== '0) begin
      bad++; $display("FAIL reset_state: grant=%b ack=%b data=%h src=%0d want all 0", ch_grant_o, status_ack_o, status_data_o, status_src_o);
    end
    status_idle_i = 1'b1;
    pulse(6'b000101);
    wait_grant(g);
    total++; if (g !== 6'b000001) begin bad++; $display("FAIL reset_pre_grant: got=%b want=000001", g); end
    ch_ack_i = 6'b000001;          // re-request ch0 on its grant cycle -> pend=101
    tick();
    ch_ack_i = '0;
    tick();                        // in HOLD, idle still 1
    sys_rst = 1'b1;
    #1;
    total++; if (ch_grant_o !== 6'b0 || status_ack_o !== 1'b0 || status_data_o !== '0 || status_src_o !== '0) begin
      bad++; $display("FAIL reset_async: grant=%b ack=%b data=%h src=%0d want all 0", ch_grant_o, status_ack_o, status_data_o, status_src_o);
    end
`ifdef STATUS_ARB_OVF_CNT_EN
    total++; if (ovf_cnt_o !== 16'h0) begin bad++; $display("FAIL reset_ovf: got=%h want=0", ovf_cnt_o); end
`endif
    tick();
    sys_rst = 1'b0;
    tick(); tick(); tick();
    total++; if (ch_grant_o !== 6'b0) begin bad++; $display("FAIL reset_pend_clr: grant=%b want=000000", ch_grant_o); end
    pulse(6'b000101);
    wait_grant(g);
    total++; if (g !== 6'b000001) begin bad++; $display("FAIL reset_rrptr: got=%b want=000001", g); end
  endtask

  task automatic test_single();
    do_reset();
    status_idle_i = 1'b1;
    ch_ack_i = 6'b000100;
    tick();                        // pend set at this edge
    ch_ack_i = '0;
    total++; if (ch_grant_o !== 6'b0) begin bad++; $display("FAIL single_early: grant=%b want=000000", ch_grant_o); end
    tick();
    total++; if (ch_grant_o !== 6'b000100 || status_ack_o !== 1'b0) begin
      bad++; $display("FAIL single_grant: grant=%b ack=%b want 000100/0", ch_grant_o, status_ack_o);
    end
    tick();
    total++; if (status_ack_o !== 1'b1 || status_src_o !== 3'd2 || status_data_o !== word(2) || ch_grant_o !== 6'b0) begin
      bad++; $display("FAIL single_ack: ack=%b src=%0d data=%h grant=%b want 1/2/%h/000000", status_ack_o, status_src_o, status_data_o, ch_grant_o, word(2));
    end
    tick();
    total++; if (status_ack_o !== 1'b0 || status_data_o !== word(2)) begin
      bad++; $display("FAIL single_ack_drop: ack=%b data=%h want 0/%h", status_ack_o, status_data_o, word(2));
    end
    release_consumer();
  endtask

  task automatic test_round_robin();
    logic [NUM_CH-1:0] g;
    do_reset();
    status_idle_i = 1'b1;
    pulse(6'b111111);
    for (int k = 0; k < NUM_CH; k++) begin
      wait_grant(g);
      total++; if (g !== 6'(1 << k)) begin bad++; $display("FAIL rr_grant%0d: got=%b want=%b", k, g, 6'(1 << k)); end
      tick();
      total++; if (status_ack_o !== 1'b1 || status_src_o !== 3'(k) || status_data_o !== word(k)) begin
        bad++; $display("FAIL rr_ack%0d: ack=%b src=%0d data=%h want 1/%0d/%h", k, status_ack_o, status_src_o, status_data_o, k, word(k));
      end
      release_consumer();
    end
    pulse(6'b100001);
    wait_grant(g);
    total++; if (g !== 6'b000001) begin bad++; $display("FAIL rr_wrap0: got=%b want=000001", g); end
    tick();
    release_consumer();
    wait_grant(g);
    total++; if (g !== 6'b100000) begin bad++; $display("FAIL rr_wrap5: got=%b want=100000", g); end
    tick();
    release_consumer();
  endtask

  task automatic test_idle_protect();
    logic [NUM_CH-1:0] g;
    bit seen;
    do_reset();
    status_idle_i = 1'b1;
    pulse(6'b000011);
    wait_grant(g);
    total++; if (g !== 6'b000001) begin bad++; $display("FAIL hold_first: got=%b want=000001", g); end
    tick();
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ch_grant_o != '0 || status_ack_o) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL hold_stay: extra grant/ack seen=%b want 0", seen); end
    release_consumer();
    wait_grant(g);
    total++; if (g !== 6'b000010) begin bad++; $display("FAIL hold_next: got=%b want=000010", g); end
    tick();
    release_consumer();
  endtask

  task automatic test_back_to_back();
    logic [NUM_CH-1:0] g;
    do_reset();
    status_idle_i = 1'b1;
    pulse(6'b000010);
    wait_grant(g);
    total++; if (g !== 6'b000010) begin bad++; $display("FAIL b2b_first: got=%b want=000010", g); end
    ch_ack_i = 6'b000010;          // new request on the grant cycle
    tick();
    ch_ack_i = '0;
    total++; if (status_ack_o !== 1'b1 || status_src_o !== 3'd1) begin
      bad++; $display("FAIL b2b_ack: ack=%b src=%0d want 1/1", status_ack_o, status_src_o);
    end
    release_consumer();
    wait_grant(g);
    total++; if (g !== 6'b000010) begin bad++; $display("FAIL b2b_regrant: got=%b want=000010", g); end
`ifdef STATUS_ARB_OVF_CNT_EN
    total++; if (ovf_cnt_o !== 16'h0) begin bad++; $display("FAIL b2b_no_drop: ovf=%h want=0", ovf_cnt_o); end
`endif
    tick();
    release_consumer();
  endtask

`ifdef STATUS_ARB_OVF_CNT_EN
  task automatic test_ovf_cnt();
    do_reset();
    status_idle_i = 1'b0;
    pulse(6'b001000);
    pulse(6'b001000);
    total++; if (ovf_cnt_o !== 16'd1) begin bad++; $display("FAIL ovf_one: got=%0d want=1", ovf_cnt_o); end
    pulse(6'b000111);              // ch0-2 not yet pending: no drops
    pulse(6'b001111);              // four duplicates in one cycle
    total++; if (ovf_cnt_o !== 16'd5) begin bad++; $display("FAIL ovf_multi: got=%0d want=5", ovf_cnt_o); end
    ch_ack_i = 6'b001000;
    for (int i = 0; i < 70000; i++) tick();
    ch_ack_i = '0;
    total++; if (ovf_cnt_o !== 16'hFFFF) begin bad++; $display("FAIL ovf_sat: got=%h want=ffff", ovf_cnt_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_idle_protect();
    test_back_to_back();
`ifdef STATUS_ARB_OVF_CNT_EN
    test_ovf_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
